counter_seq_ctrl: RTL and testbench

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_ctrl.sv | 83 ++++++++
 tb/tb_counter_seq_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Start/stop/hold controlled up-counter with a latched terminal count,
// selectable one-shot or periodic (auto-reload) behaviour and a terminal-count tick.
module counter_seq_ctrl #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic         stop,
    input  logic         hold,
    input  logic         periodic,
    input  logic [N-1:0] tc_in,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         tick,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    logic [N-1:0] tc_lat;
    logic         mode_lat;

    // NOTE: every register, including the latched terminal count and mode, is
    // cleared by the async reset so no X can leak into the compare after power-up.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            q        <= '0;
            tc_lat   <= '0;
            mode_lat <= 1'b0;
            tick     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment in
            // this block overrides this default pulse-clear for the same edge.
            tick <= 1'b0;
            if (stop) begin
                // Stop outranks everything; in IDLE this simply re-asserts IDLE.
                state <= IDLE;
                q     <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            tc_lat   <= tc_in;
                            mode_lat <= periodic;
                            q        <= '0;
                            state    <= RUN;
                        end
                    end
                    RUN: begin
                        if (hold) begin
                            state <= HOLD;
                        end else if (q == tc_lat) begin
                            tick <= 1'b1;
                            if (mode_lat) q <= '0;
                            else          state <= DONE;
                        end else begin
                            q <= q + ONE;
                        end
                    end
                    HOLD: begin
                        // Leaving HOLD costs one edge with q frozen (resume bubble).
                        if (!hold) state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == RUN) || (state == HOLD);
    assign done = (state == DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed scenarios followed by
// random stimulus, all compared against a rule-level reference model.
module tb_counter_seq_ctrl;

    localparam int N = 6;
    localparam int MAXV = (1 << N) - 1;

    logic         clk;
    logic         clr_n;
    logic         start;
    logic         stop;
    logic         hold;
    logic         periodic;
    logic [N-1:0] tc_in;
    logic [N-1:0] q;
    logic         busy;
    logic         tick;
    logic         done;

    int errors = 0;
    int checks = 0;

    counter_seq_ctrl #(.N(N)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .periodic (periodic),
        .tc_in    (tc_in),
        .q        (q),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the sequence is doing, in plain terms.
    bit m_active;    // a count sequence has been accepted and not finished/stopped
    bit m_paused;    // active but frozen by hold
    bit m_finished;  // one-shot sequence reached its terminal count
    int m_q;
    int m_tc;
    bit m_per;
    bit m_tick;

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_finished = 0;
        m_q = 0; m_tc = 0; m_per = 0; m_tick = 0;
    endtask

    task automatic model_edge(input bit s, input bit p, input bit h, input bit per, input int tc);
        m_tick = 0;
        if (p) begin
            m_active = 0; m_paused = 0; m_finished = 0; m_q = 0;
        end else if (!m_active && s) begin
            m_tc = tc; m_per = per; m_q = 0;
            m_active = 1; m_paused = 0; m_finished = 0;
        end else if (m_active && m_paused) begin
            if (!h) m_paused = 0;
        end else if (m_active) begin
            if (h) m_paused = 1;
            else if (m_q == m_tc) begin
                m_tick = 1;
                if (m_per) m_q = 0;
                else begin m_active = 0; m_finished = 1; end
            end else m_q = m_q + 1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".q"},    int'(q),    m_q);
        check({tag, ".tick"}, int'(tick), int'(m_tick));
        check({tag, ".busy"}, int'(busy), int'(m_active));
        check({tag, ".done"}, int'(done), int'(m_finished));
    endtask

    // Drive one cycle of inputs, clock it, then compare 1 time unit after the edge.
    task automatic step(input string tag, input bit s, input bit p, input bit h,
                        input bit per, input int tc);
        start = s; stop = p; hold = h; periodic = per; tc_in = N'(tc);
        @(posedge clk);
        model_edge(s, p, h, per, tc);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, periodic, int'(tc_in));
    endtask

    initial begin
        clr_n = 1'b0; start = 0; stop = 0; hold = 0; periodic = 0; tc_in = '0;
        model_reset();
        #3;
        check_outputs("reset");
        #5 clr_n = 1'b1;

        // One-shot count to 5, then DONE holds q.
        step("os5_start", 1, 0, 0, 0, 5);
        idle_steps("os5_run", 7);
        step("os5_stop", 0, 1, 0, 0, 5);
        step("idle_stop", 0, 1, 0, 0, 5);

        // Periodic wrap at 3, with tc_in/periodic wiggled mid-run.
        step("per3_start", 1, 0, 0, 1, 3);
        for (int i = 0; i < 10; i++) step("per3_run", 0, 0, 0, i[0], 17 + i);
        step("per3_start_ignored", 1, 0, 0, 0, 9);
        step("per3_stop", 0, 1, 0, 0, 9);

        // Hold for 3 cycles at q=2, then resume bubble and continue.
        step("hold_start", 1, 0, 0, 0, 10);
        idle_steps("hold_pre", 2);
        check("hold_at_q2", int'(q), 2);
        for (int i = 0; i < 3; i++) step("hold_on", 0, 0, 1, 0, 10);
        step("hold_bubble", 0, 0, 0, 0, 10);
        check("hold_bubble_q", int'(q), 2);
        idle_steps("hold_resume", 3);

        // Priority: stop+start in RUN -> IDLE; start+hold in IDLE -> RUN.
        step("prio_stop_start", 1, 1, 0, 0, 10);
        step("prio_start_hold", 1, 0, 1, 0, 7);
        idle_steps("prio_after", 4);

        // DONE restart relatches new parameters.
        idle_steps("to_done", 6);
        step("done_restart", 1, 0, 0, 1, 2);
        idle_steps("restart_run", 6);
        step("restart_stop", 0, 1, 0, 0, 2);

        // Async reset between edges at q=4.
        step("ar_start", 1, 0, 0, 0, 20);
        idle_steps("ar_run", 4);
        #2 clr_n = 1'b0;
        model_reset();
        #1;
        check_outputs("ar_low");
        #1 clr_n = 1'b1;
        step("ar_restart", 1, 0, 0, 0, 4);
        idle_steps("ar_restart_run", 6);

        // tc=0 one-shot and periodic, then full range tc=63 periodic.
        step("tc0_os", 1, 0, 0, 0, 0);
        step("tc0_os_done", 0, 0, 0, 0, 0);
        step("tc0_os_stay", 0, 0, 0, 0, 0);
        step("tc0_per", 1, 0, 0, 1, 0);
        idle_steps("tc0_per_run", 5);
        step("tc0_per_stop", 0, 1, 0, 1, 0);
        step("tc63_start", 1, 0, 0, 1, MAXV);
        for (int i = 0; i < 70; i++) step("tc63_run", 0, 0, 0, 0, 5);
        step("tc63_stop", 0, 1, 0, 0, 5);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            int r_tc;
            r_tc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXV))
                                               : int'($urandom_range(0, 6));
            step("rand",
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 40) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 1,
                 r_tc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
